cpu_collector: RTL and testbench
================================

CPU_COLLECTOR -- requirements
Module: cpu_collector

Interface
REQ-001 Parameter CPU_NB, default 4, meaning: number of upstream cpu channels (range 1..16).
REQ-002 Parameter FIFO_DEPTH, default 8, meaning: output buffer entries (power of two, 2..64).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cpu_data_vld  input  CPU_NB  per-channel valid; channel i holds its value and data until accepted.
REQ-006 cpu_data  input  CPU_NB x 64  per-channel payload.
REQ-007 cpu_transactions_done  input  CPU_NB  per-channel "no more data" flag; sticky high once set.
REQ-008 cpu_data_rdy  output  CPU_NB  per-channel ready; combinational.
REQ-009 out_vld  output  1  head of buffer valid.
REQ-010 out_rdy  input  1  downstream ready.
REQ-011 out_data  output  64  head payload.
REQ-012 out_src  output  4  channel index of the head payload.
REQ-013 rx_count  output  32  number of words popped downstream.
REQ-014 checksum  output  64  XOR of all popped out_data words.
REQ-015 all_done  output  1  all channels finished and buffer drained.

Function
REQ-016 Transfer on channel i SHALL occur at a posedge where cpu_data_vld[i] and cpu_data_rdy[i] are both high.
REQ-017 At most one channel SHALL be accepted per cycle; at most one cpu_data_rdy bit SHALL be high in any cycle.
REQ-018 Arbitration SHALL be round-robin: search begins at (last_grant+1) mod CPU_NB; the first channel with vld high wins; last_grant updates only on an actual transfer.
REQ-019 cpu_data_rdy[g] SHALL be high only if g is the winner, its vld is high, and the buffer holds fewer than FIFO_DEPTH entries.
REQ-020 Full buffer: no acceptance in that cycle, even if a pop occurs in the same cycle; there is no full-bypass path, and out_rdy SHALL NOT combinationally affect cpu_data_rdy.
REQ-021 Accepted {data, index} SHALL be written at the tail at the transfer edge and SHALL appear on out_data/out_src no earlier than the next cycle; minimum latency is 1 cycle.
REQ-022 out_vld SHALL equal "buffer not empty"; out_data/out_src SHALL show the head (show-ahead).
REQ-023 A pop SHALL occur at a posedge with out_vld and out_rdy high; output order SHALL equal acceptance order.
REQ-024 A simultaneous push and pop SHALL leave the occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 Each pop SHALL increment rx_count by 1 (wrapping at 2^32) and SHALL set checksum to checksum XOR out_data.
REQ-026 all_done SHALL be registered: set at the posedge where all cpu_transactions_done bits are high, no cpu_data_vld bit is high, and the buffer is empty; once set, it SHALL stay high until reset.
REQ-027 Popping the last word SHALL not raise all_done in the same edge; all_done rises one cycle after empty is observed.
REQ-028 Inputs while out_vld is low and out_rdy is high SHALL have no effect on rx_count or checksum.

Reset
REQ-029 Asserting rst SHALL immediately clear the pointers, occupancy, last_grant (to CPU_NB-1, so channel 0 has first priority), rx_count, checksum, and all_done.
REQ-030 During reset, out_vld and all cpu_data_rdy bits SHALL be 0; out_data and out_src are don't-care.
REQ-031 Reset mid-operation SHALL discard buffered words; an upstream word with vld high is not considered transferred.
REQ-032 The first acceptance SHALL be possible at the first posedge after rst deasserts.

Verification
REQ-033 Single channel: ch0 sends 0x1, 0x2, 0x3 with out_rdy=1 -> out_data 0x1, 0x2, 0x3 with out_src=0, rx_count=3, checksum=0x0.
REQ-034 Round-robin: all 4 channels hold vld with data 0xA0..0xA3, out_rdy=1 -> acceptance order ch0, ch1, ch2, ch3, and one rdy per cycle.
REQ-035 Backpressure: out_rdy=0, FIFO_DEPTH=8, ch1 streams -> exactly 8 accepted, then cpu_data_rdy=0; raise out_rdy -> 8 pops in order, then streaming resumes.
REQ-036 Full plus pop: buffer full, out_rdy=1, ch2 vld -> pop occurs, no push that cycle, push on the next cycle.
REQ-037 Completion: all channels assert done after 2 words each and the buffer drains -> all_done=1 one cycle after empty, rx_count=8, checksum=XOR of the 8 words.
REQ-038 Reset mid-stream: 5 words buffered, pulse rst asynchronously -> out_vld=0, rx_count=0, and checksum=0 immediately, with no posedge required.

Source files
------------

// File: rtl/cpu_collector_if.sv
// Handshake bundle between the cpu channels, the collector and the downstream consumer.
// The collector connects through the slave modport.
interface cpu_collector_if #(
  parameter int unsigned CPU_NB = 4
);
  logic [CPU_NB-1:0]       cpu_data_vld;
  logic [CPU_NB-1:0][63:0] cpu_data;
  logic [CPU_NB-1:0]       cpu_transactions_done;
  logic [CPU_NB-1:0]       cpu_data_rdy;
  logic                    out_vld;
  logic                    out_rdy;
  logic [63:0]             out_data;
  logic [3:0]              out_src;

  modport master (
    output cpu_data_vld, cpu_data, cpu_transactions_done, out_rdy,
    input  cpu_data_rdy, out_vld, out_data, out_src
  );

  modport slave (
    input  cpu_data_vld, cpu_data, cpu_transactions_done, out_rdy,
    output cpu_data_rdy, out_vld, out_data, out_src
  );
endinterface

// File: rtl/cpu_collector.sv
// Round-robin collector: merges CPU_NB 64-bit channels into one show-ahead buffer,
// counts and XORs popped words, and flags completion once every channel is done and drained.
module cpu_collector #(
  parameter int unsigned CPU_NB     = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  cpu_collector_if.slave    bus,
  output logic [31:0]       rx_count,
  output logic [63:0]       checksum,
  output logic              all_done
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned IW = (CPU_NB > 1) ? $clog2(CPU_NB) : 1;

  logic [63:0]   mem_data [FIFO_DEPTH];
  logic [3:0]    mem_src  [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [3:0]    last_grant;
  logic [IW-1:0] winner, cand;
  logic          found, full, push, pop;

  // Search starts one past the last granted channel.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < CPU_NB; k++) begin
      cand = IW'((32'(last_grant) + 32'd1 + k) % CPU_NB);
      if (!found && bus.cpu_data_vld[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Full blocks acceptance regardless of a same-cycle pop, keeping out_rdy off the rdy path.
  assign full = (count == (PW+1)'(FIFO_DEPTH));
  assign push = found && !full && !rst;
  assign pop  = (count != '0) && bus.out_rdy;

  always_comb begin
    bus.cpu_data_rdy = '0;
    if (push) bus.cpu_data_rdy[winner] = 1'b1;
  end

  assign bus.out_vld  = (count != '0);
  assign bus.out_data = mem_data[rd_ptr];
  assign bus.out_src  = mem_src[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= bus.cpu_data[winner];
      mem_src[wr_ptr]  <= 4'(winner);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= 4'(CPU_NB - 1);
      rx_count   <= '0;
      checksum   <= '0;
      all_done   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + 1'b1;
        last_grant <= 4'(winner);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        rx_count <= rx_count + 32'd1;
        checksum <= checksum ^ bus.out_data;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // Uses pre-edge occupancy, so the edge that pops the last word cannot set it.
      if (&bus.cpu_transactions_done && !(|bus.cpu_data_vld) && count == '0)
        all_done <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cpu_collector.sv
// Self-checking bench for cpu_collector: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_cpu_collector;
  localparam int N = 4;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rx_count;
  logic [63:0] checksum;
  logic        all_done;

  cpu_collector_if #(.CPU_NB(N)) bus ();

  cpu_collector #(.CPU_NB(N), .FIFO_DEPTH(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .rx_count (rx_count),
    .checksum (checksum),
    .all_done (all_done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] q_data[$];
  int          q_src[$];
  int          m_lg;
  logic [31:0] m_rx;
  logic [63:0] m_cs;
  logic [63:0] m_acc_xor;
  bit          m_ad;
  logic [N-1:0] accepted;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q_data.delete();
    q_src.delete();
    m_lg      = N - 1;
    m_rx      = '0;
    m_cs      = '0;
    m_acc_xor = '0;
    m_ad      = 1'b0;
    accepted  = '0;
  endtask

  // Asynchronous reset pulse placed mid-cycle; state must clear without any clock edge.
  task automatic do_reset(input string tag);
    bus.cpu_data_vld = '1;
    rst = 1'b1;
    #1;
    check({tag, "_out_vld"}, bus.out_vld, 0);
    check({tag, "_rdy"}, bus.cpu_data_rdy, 0);
    check({tag, "_rx"}, rx_count, 0);
    check({tag, "_cs"}, checksum, 0);
    check({tag, "_done"}, all_done, 0);
    rst = 1'b0;
    bus.cpu_data_vld = '0;
    model_reset();
  endtask

  // One clock cycle: compare outputs to the model, then advance the model at the edge.
  task automatic step();
    int          w;
    bit          found;
    bit          push, pop, donecond;
    logic [N-1:0] erdy;
    logic [63:0] pd;
    #1;
    found = 0;
    w     = 0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_lg + 1 + k) % N;
      if (!found && bus.cpu_data_vld[c]) begin
        found = 1;
        w     = c;
      end
    end
    erdy = '0;
    if (found && q_data.size() < D) erdy[w] = 1'b1;
    check("rdy", bus.cpu_data_rdy, erdy);
    check("out_vld", bus.out_vld, q_data.size() != 0);
    if (q_data.size() != 0) begin
      check("out_data", bus.out_data, q_data[0]);
      check("out_src", bus.out_src, q_src[0]);
    end
    check("rx_count", rx_count, m_rx);
    check("checksum", checksum, m_cs);
    check("all_done", all_done, m_ad);
    push     = (erdy != 0);
    pop      = (q_data.size() != 0) && bus.out_rdy;
    donecond = (&bus.cpu_transactions_done) && (bus.cpu_data_vld == 0) && (q_data.size() == 0);
    pd       = bus.cpu_data[w];
    accepted = '0;
    @(posedge clk);
    if (pop) begin
      m_rx++;
      m_cs ^= q_data[0];
      void'(q_data.pop_front());
      void'(q_src.pop_front());
    end
    if (push) begin
      q_data.push_back(pd);
      q_src.push_back(w);
      m_lg = w;
      m_acc_xor ^= pd;
      accepted[w] = 1'b1;
    end
    if (donecond) m_ad = 1'b1;
    #1;
  endtask

  // Accepted channels drop vld; idle enabled channels may present a fresh word; pending ones hold.
  task automatic drive(input logic [N-1:0] mask, input int pct);
    for (int i = 0; i < N; i++) begin
      if (accepted[i]) bus.cpu_data_vld[i] = 1'b0;
      if (!bus.cpu_data_vld[i] && mask[i] && $urandom_range(0, 99) < pct) begin
        bus.cpu_data_vld[i] = 1'b1;
        bus.cpu_data[i]     = {$urandom, $urandom};
      end
    end
  endtask

  initial begin
    int acc;
    int bound;
    int sent [N];
    logic [N-1:0] mask;
    rst = 1'b1;
    bus.cpu_data_vld          = '0;
    bus.cpu_data              = '0;
    bus.cpu_transactions_done = '0;
    bus.out_rdy               = 1'b0;
    #1;

    // Single channel, three words.
    do_reset("rst_a");
    bus.out_rdy = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      bus.cpu_data[0]     = 64'(v);
      bus.cpu_data_vld[0] = 1'b1;
      step();
      check("single_acc", accepted[0], 1);
      bus.cpu_data_vld[0] = 1'b0;
    end
    repeat (3) step();
    check("single_rx", rx_count, 3);
    check("single_cs", checksum, 0);

    // Round robin from reset.
    do_reset("rst_b");
    for (int i = 0; i < N; i++) bus.cpu_data[i] = 64'hA0 + 64'(i);
    bus.cpu_data_vld = '1;
    for (int k = 0; k < N; k++) begin
      #1;
      check("rr_grant", bus.cpu_data_rdy, 64'(1) << k);
      step();
      bus.cpu_data_vld = bus.cpu_data_vld & ~accepted;
    end
    repeat (5) step();
    check("rr_rx", rx_count, 4);

    // Backpressure fill, then full plus pop.
    do_reset("rst_c");
    bus.out_rdy = 1'b0;
    acc = 0;
    repeat (12) begin
      drive(4'b0010, 100);
      step();
      if (accepted[1]) acc++;
    end
    check("bp_accepts", acc, D);
    #1;
    check("bp_rdy_full", bus.cpu_data_rdy, 0);
    bus.cpu_data_vld[2] = 1'b1;
    bus.cpu_data[2]     = {$urandom, $urandom};
    bus.out_rdy         = 1'b1;
    #1;
    check("fullpop_nopush", bus.cpu_data_rdy, 0);
    step();
    check("fullpop_popped", rx_count, 1);
    check("fullpop_no_acc", accepted, 0);
    #1;
    check("fullpop_push", bus.cpu_data_rdy, 4'b0100);
    step();
    repeat (30) begin
      drive(4'b0110, 100);
      step();
    end

    // Random traffic.
    repeat (400) begin
      bus.out_rdy = ($urandom_range(0, 99) < 60);
      drive('1, 50);
      step();
    end

    // Reset with five words buffered.
    bus.out_rdy = 1'b1;
    bound = 0;
    while ((q_data.size() != 0 || bus.cpu_data_vld != 0) && bound < 100) begin
      drive('0, 0);
      step();
      bound++;
    end
    check("drain_in_time", bound < 100, 1);
    bus.out_rdy = 1'b0;
    bound = 0;
    while (q_data.size() < 5 && bound < 50) begin
      drive(4'b1000, 100);
      step();
      bound++;
    end
    check("fill5_in_time", q_data.size(), 5);
    do_reset("rst_mid");

    // Completion: two words per channel, then done.
    for (int i = 0; i < N; i++) sent[i] = 0;
    bus.cpu_transactions_done = '0;
    bound = 0;
    while (!m_ad && bound < 300) begin
      for (int i = 0; i < N; i++) begin
        if (accepted[i]) begin
          sent[i]++;
          if (sent[i] == 2) bus.cpu_transactions_done[i] = 1'b1;
        end
        mask[i] = (sent[i] < 2);
      end
      bus.out_rdy = ($urandom_range(0, 99) < 60);
      drive(mask, 60);
      step();
      bound++;
    end
    check("done_in_time", m_ad, 1);
    check("done_rx", rx_count, 8);
    check("done_cs", checksum, m_acc_xor);
    check("done_flag", all_done, 1);
    repeat (3) step();
    check("done_sticky", all_done, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
